sha_digest_reader: RTL and testbench

//  Unloads the final hash state from the S32 SHA-256/224 core state storage after compression completes.
//  - Each stored word is WORD_SIZE+1 bits in write_word format: bit[WORD_SIZE] is the order flag; when set, the two halves are swapped.
//  - The block decodes each word with the same transform as lw_sha_pkg::read_word.
//  - Decoded digest words H0..H7 (H0..H6 for SHA-224) stream out on a valid/ready interface to the host or DMA.
//  - It is the reader counterpart of the write_word path that the round logic uses to store state.

---
 rtl/lw_sha_pkg.sv | 26 ++
 rtl/sha_digest_reader_if.sv | 22 ++
 rtl/sha_digest_reader.sv | 99 +++++++++
 tb/tb_sha_digest_reader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lw_sha_pkg.sv
// Shared S32 SHA-256/224 definitions: stored-word format, digest reader states
// and the read_word decode used by every consumer of the state storage.
package lw_sha_pkg;

    localparam int WORD_SIZE = 32;
    localparam int NUM_WORDS = 8;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_READ,
        RD_CAPT,
        RD_SEND,
        RD_DONE
    } digest_rd_state_t;

    localparam logic [2:0] DIGEST_LAST_256 = 3'd7;
    localparam logic [2:0] DIGEST_LAST_224 = 3'd6;

    // Stored words carry an order flag above the data; a set flag means the
    // two halves were written swapped and must be swapped back.
    function automatic logic [WORD_SIZE-1:0] read_word(input logic [WORD_SIZE:0] w);
        return w[WORD_SIZE] ? {w[WORD_SIZE/2-1:0], w[WORD_SIZE-1:WORD_SIZE/2]}
                            : w[WORD_SIZE-1:0];
    endfunction

endpackage

// File: rtl/sha_digest_reader_if.sv
// State-storage read port plus the decoded digest stream of the digest reader.
interface sha_digest_reader_if #(
    parameter int WORD_SIZE = 32
);
    logic                 rd_en_o;
    logic [2:0]           rd_addr_o;
    logic [WORD_SIZE:0]   rd_data_i;
    logic [WORD_SIZE-1:0] dout_o;
    logic                 dout_valid_o;
    logic                 dout_ready_i;
    logic                 dout_last_o;

    modport master (
        output rd_en_o, rd_addr_o, dout_o, dout_valid_o, dout_last_o,
        input  rd_data_i, dout_ready_i
    );

    modport slave (
        input  rd_en_o, rd_addr_o, dout_o, dout_valid_o, dout_last_o,
        output rd_data_i, dout_ready_i
    );
endinterface

// File: rtl/sha_digest_reader.sv
// Unloads the final hash state word by word from core storage, decodes the
// order flag and streams H0..H7 (H0..H6 for SHA-224) over valid/ready.
module sha_digest_reader
    import lw_sha_pkg::*;
#(
    parameter int WORD_SIZE = lw_sha_pkg::WORD_SIZE,
    parameter int NUM_WORDS = lw_sha_pkg::NUM_WORDS
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                mode224_i,
    output logic                busy_o,
    output logic                done_o,
    sha_digest_reader_if.master bus
);

    localparam logic [2:0] LAST_FULL = (NUM_WORDS == 8) ? DIGEST_LAST_256
                                                        : 3'(NUM_WORDS - 1);

    digest_rd_state_t     state, state_nxt;
    logic [2:0]           idx;
    logic                 mode224;
    logic [WORD_SIZE-1:0] dout_q;
    logic                 valid_q;
    logic                 last_q;
    logic [2:0]           last_idx;
    logic                 handshake;

    assign last_idx  = mode224 ? DIGEST_LAST_224 : LAST_FULL;
    assign handshake = valid_q && bus.dout_ready_i;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process ordering in simulation.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= RD_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: default assignment first, so no path through the case leaves
    // state_nxt unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE: if (start_i) state_nxt = RD_READ;
            RD_READ: state_nxt = RD_CAPT;
            RD_CAPT: state_nxt = RD_SEND;
            RD_SEND: if (handshake) state_nxt = last_q ? RD_DONE : RD_READ;
            RD_DONE: state_nxt = RD_IDLE;
            default: state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        bus.rd_en_o   = (state == RD_READ);
        bus.rd_addr_o = idx;
        busy_o        = (state != RD_IDLE);
        done_o        = (state == RD_DONE);
    end

    // NOTE: the output word register is reset along with the control flops,
    // so a mid-unload reset leaves every visible output at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx     <= '0;
            mode224 <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                RD_IDLE: begin
                    // Mode is captured only here, so a start during busy cannot change it.
                    if (start_i) begin
                        mode224 <= mode224_i;
                        idx     <= '0;
                    end
                end
                RD_CAPT: begin
                    dout_q  <= read_word(bus.rd_data_i);
                    valid_q <= 1'b1;
                    last_q  <= (idx == last_idx);
                end
                RD_SEND: begin
                    if (handshake) begin
                        valid_q <= 1'b0;
                        if (!last_q) idx <= idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dout_o       = dout_q;
    assign bus.dout_valid_o = valid_q;
    assign bus.dout_last_o  = last_q;

endmodule

// File: tb/tb_sha_digest_reader.sv
// Scoreboard bench for sha_digest_reader: a storage model answers reads, the
// stimulus queues the logical digest words, a monitor pops and compares them.
module tb_sha_digest_reader;
    import lw_sha_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic mode224 = 1'b0;
    logic busy, done;

    always #5 clk = ~clk;

    sha_digest_reader_if #(.WORD_SIZE(32)) bus ();

    sha_digest_reader #(.WORD_SIZE(32), .NUM_WORDS(8)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .mode224_i(mode224),
        .busy_o   (busy),
        .done_o   (done),
        .bus      (bus)
    );

    typedef struct {
        logic [31:0] w;
        logic        last;
    } exp_t;

    exp_t        q[$];
    logic [31:0] digest[8];
    logic [32:0] mem[8];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          accepted = 0;
    int          done_count = 0;
    int          done_cyc = 0;
    int          last_hs_cyc = 0;
    logic        done_expected = 1'b0;
    logic        cur_m224 = 1'b0;
    logic        rand_ready = 1'b0;
    logic        ready_man = 1'b1;
    logic        rnd_bit = 1'b1;

    assign bus.dout_ready_i = rand_ready ? rnd_bit : ready_man;

    // Storage: read data appears one cycle after the strobe.
    always @(posedge clk) if (bus.rd_en_o) bus.rd_data_i <= mem[bus.rd_addr_o];

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic        held = 1'b0;
    logic [31:0] held_w;
    logic        held_last;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_en_o) begin
                rd_cnt++;
                if (cur_m224) check("rd_addr_224", 64'(bus.rd_addr_o <= 3'd6), 64'd1);
            end
            if (held && bus.dout_valid_o) begin
                check("stall_dout_stable", 64'(bus.dout_o), 64'(held_w));
                check("stall_last_stable", 64'(bus.dout_last_o), 64'(held_last));
            end
            held      = bus.dout_valid_o && !bus.dout_ready_i;
            held_w    = bus.dout_o;
            held_last = bus.dout_last_o;
            if (bus.dout_valid_o && bus.dout_ready_i) begin
                accepted++;
                if (bus.dout_last_o) last_hs_cyc = cyc;
                if (q.size() == 0) begin
                    check("unexpected_word", 64'(bus.dout_o), 64'hdead);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("word", 64'(bus.dout_o), 64'(e.w));
                    check("last", 64'(bus.dout_last_o), 64'(e.last));
                end
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
                check("done_expected", 64'(done_expected), 64'd1);
                check("done_queue_drained", 64'(q.size()), 64'd0);
            end
        end else begin
            held = 1'b0;
        end
    end

    // Storage encoding: a flagged word is held with its halves swapped.
    task automatic fill(input int pol);
        for (int i = 0; i < 8; i++) begin
            logic flag;
            flag = (pol == 1) ? logic'(i % 2) : (pol == 2) ? logic'($urandom_range(0, 1)) : 1'b0;
            mem[i] = flag ? {1'b1, digest[i][15:0], digest[i][31:16]} : {1'b0, digest[i]};
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(bus.dout_valid_o), 64'd0);
        check({tag, "_last"},  64'(bus.dout_last_o),  64'd0);
        check({tag, "_dout"},  64'(bus.dout_o),       64'd0);
        check({tag, "_rd_en"}, 64'(bus.rd_en_o),      64'd0);
        check({tag, "_busy"},  64'(busy),             64'd0);
        check({tag, "_done"},  64'(done),             64'd0);
    endtask

    // One unload. stall_word / reset_word select a word index (-1 = off).
    task automatic run_unload(input logic m224, input bit lat_chk, input int stall_word,
                              input int reset_word, input bit glitch);
        int nwords, d0, r0, a0, t0, n, stall_cnt;
        bit stall_done, aborted;
        nwords = m224 ? 7 : 8;
        for (int i = 0; i < nwords; i++) q.push_back('{w: digest[i], last: (i == nwords - 1)});
        n = 0;
        while (busy && n < 100) begin @(posedge clk); #1; n++; end
        cur_m224 = m224;
        d0 = done_count; r0 = rd_cnt; a0 = accepted; t0 = cyc;
        done_expected = 1'b1;
        mode224 = m224;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode224 = logic'($urandom_range(0, 1));
        if (lat_chk) begin
            check("rd_en_at_t1", 64'(bus.rd_en_o), 64'd1);
            @(posedge clk); #1;
            check("valid_low_t2", 64'(bus.dout_valid_o), 64'd0);
            @(posedge clk); #1;
            check("valid_at_t3", 64'(bus.dout_valid_o), 64'd1);
        end
        n = 0; stall_cnt = 0; stall_done = 0; aborted = 0;
        while (done_count == d0 && n < 3000 && !aborted) begin
            if (glitch && n == 4) begin
                start = 1'b1;
                mode224 = ~m224;
            end else begin
                start = 1'b0;
            end
            if (stall_word >= 0 && !stall_done && accepted - a0 == stall_word) begin
                if (bus.dout_valid_o) stall_cnt++;
                ready_man = (stall_cnt >= 11);
                if (stall_cnt >= 11) stall_done = 1;
            end
            if (reset_word >= 0 && accepted - a0 == reset_word) begin
                ready_man = 1'b0;
                if (bus.dout_valid_o) begin
                    rst = 1'b1;
                    @(posedge clk); #1;
                    check_idle_outputs("mid_reset");
                    rst = 1'b0;
                    q.delete();
                    done_expected = 1'b0;
                    aborted = 1;
                end
            end
            if (!aborted) begin
                @(posedge clk); #1;
                n++;
            end
        end
        start = 1'b0;
        ready_man = 1'b1;
        if (aborted) begin
            repeat (6) @(posedge clk);
            #1;
            check("no_done_after_reset", 64'(done_count - d0), 64'd0);
        end else begin
            check("done_once", 64'(done_count - d0), 64'd1);
            check("reads_per_unload", 64'(rd_cnt - r0), 64'(nwords));
            check("words_per_unload", 64'(accepted - a0), 64'(nwords));
            if (lat_chk) begin
                // Eight words at three cycles each: the last handshake lands
                // 24 cycles after start, and the done pulse follows it.
                check("last_hs_latency", 64'(last_hs_cyc - t0), 64'd24);
                check("done_latency", 64'(done_cyc - t0), 64'd25);
            end
        end
        done_expected = 1'b0;
        cur_m224 = 1'b0;
    endtask

    task automatic load_abc256();
        digest[0] = 32'hba7816bf; digest[1] = 32'h8f01cfea;
        digest[2] = 32'h414140de; digest[3] = 32'h5dae2223;
        digest[4] = 32'hb00361a3; digest[5] = 32'h96177a9c;
        digest[6] = 32'hb410ff61; digest[7] = 32'hf20015ad;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        load_abc256();
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // SHA-256 "abc", plain storage, latency checked.
        run_unload(1'b0, 1'b1, -1, -1, 1'b0);
        // Same digest with odd addresses stored swapped.
        fill(1);
        run_unload(1'b0, 1'b1, -1, -1, 1'b0);

        // SHA-224 "abc"; H7 holds a marker that must never be read out.
        digest[0] = 32'h23097d22; digest[1] = 32'h3405d822;
        digest[2] = 32'h8642a477; digest[3] = 32'hbda255b3;
        digest[4] = 32'h2aadbce4; digest[5] = 32'hbda0b3f7;
        digest[6] = 32'he36c9da7; digest[7] = 32'ha5a5a5a5;
        fill(2);
        run_unload(1'b1, 1'b0, -1, -1, 1'b0);

        // Backpressure on word 3.
        load_abc256();
        fill(2);
        run_unload(1'b0, 1'b0, 3, -1, 1'b0);

        // Reset while word 5 waits in SEND, then a clean full unload.
        run_unload(1'b0, 1'b0, -1, 5, 1'b0);
        run_unload(1'b0, 1'b0, -1, -1, 1'b0);

        // Start pulses during busy with the opposite mode are ignored.
        run_unload(1'b0, 1'b0, -1, -1, 1'b1);
        run_unload(1'b1, 1'b0, -1, -1, 1'b1);

        // Randomized digests, flags, modes and ready.
        rand_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 8; i++) digest[i] = $urandom;
            fill(2);
            run_unload(logic'($urandom_range(0, 1)), 1'b0, -1, -1, (k % 4) == 0);
        end
        rand_ready = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
